// File: rtl/hallsensor_axi_slave.sv
// -----------------------------------------------------------------------------
// hallsensor_axi_slave
//   AXI4-Lite register slave that decodes a 3-wire Hall commutation sensor into
//   a signed position count, a direction flag and the edge-to-edge period.
//
//   Ports
//     S_AXI_ACLK / S_AXI_ARESETN   clock, asynchronous active-low reset
//     S_AXI_AW* / S_AXI_W* / S_AXI_B*   AXI4-Lite write address/data/response
//     S_AXI_AR* / S_AXI_R*              AXI4-Lite read address/data
//     hall_in[2:0]   raw asynchronous Hall inputs {C,B,A}
//     hall_dir       last valid direction (1 = forward)
//     hall_stall     no valid edge for TIMEOUT cycles while enabled
//
//   Register map (word offsets)
//     0x00 CTRL     [0] enable, [1] clear (write-1 pulse, reads 0), [2] dir_invert
//     0x04 TIMEOUT  stall threshold in cycles, 0 disables stall detection
//     0x08 SCRATCH0 / 0x0C SCRATCH1
//     0x10 STATUS   [2:0] synced hall, [3] dir, [4] stall, [5] invalid (sticky)
//     0x14 POSITION signed count
//     0x18 PERIOD   cycles between the last two valid edges
//     0x1C reserved, reads 0
//
//   Build option: define HALL_SLVERR_EN to answer writes to 0x10-0x1C and
//   reads of 0x1C with SLVERR; otherwise every response is OKAY.
// -----------------------------------------------------------------------------
module hallsensor_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic [2:0]                        hall_in,
    output logic                              hall_dir,
    output logic                              hall_stall
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_e;

    wstate_e     w_state_q, w_state_d;
    rstate_e     r_state_q, r_state_d;

    logic [31:0] ctrl_q;
    logic [31:0] timeout_q;
    logic [31:0] scratch0_q;
    logic [31:0] scratch1_q;
    logic        clr_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic [2:0]  sync1_q, sync2_q, prev_q;
    logic [31:0] pos_q, pos_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic        invalid_q, invalid_d;
    logic        dir_q, dir_d;

    logic        wr_en;
    logic [2:0]  wsel;
    logic [1:0]  wr_resp;
    logic [31:0] rd_mux;
    logic [1:0]  rd_resp;
    logic        enable;
    logic        dir_invert;
    logic        hall_change, step_fwd, step_bwd, step_bad, step_up;

    // Protection bits and sub-word address bits carry no meaning here.
    logic        unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign enable     = ctrl_q[0];
    assign dir_invert = ctrl_q[2];

    // ---------------------------------------------------------------- write FSM
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d     = w_state_q;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    w_state_d = W_ACK;
                end
            end
            W_ACK: begin
                S_AXI_AWREADY = 1'b1;
                S_AXI_WREADY  = 1'b1;
                w_state_d     = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign S_AXI_BRESP = bresp_q;

    // Both channels are valid and ready in W_ACK, so the register commit
    // happens on the handshake edge using the live bus values.
    assign wr_en = (w_state_q == W_ACK);
    assign wsel  = S_AXI_AWADDR[4:2];

    always_comb begin
        wr_resp = 2'b00;
`ifdef HALL_SLVERR_EN
        if (wsel[2]) begin
            wr_resp = 2'b10;
        end
`endif
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q     <= '0;
            timeout_q  <= '0;
            scratch0_q <= '0;
            scratch1_q <= '0;
            clr_q      <= 1'b0;
            bresp_q    <= 2'b00;
        end else begin
            clr_q <= 1'b0;
            if (wr_en) begin
                bresp_q <= wr_resp;
                for (int unsigned b = 0; b < 4; b++) begin
                    if (S_AXI_WSTRB[b]) begin
                        case (wsel)
                            3'd0:    ctrl_q[8*b +: 8]     <= S_AXI_WDATA[8*b +: 8];
                            3'd1:    timeout_q[8*b +: 8]  <= S_AXI_WDATA[8*b +: 8];
                            3'd2:    scratch0_q[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                            3'd3:    scratch1_q[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                            default: ;
                        endcase
                    end
                end
                if (wsel == 3'd0) begin
                    // clear is a pulse: never stored, acted on the following cycle
                    ctrl_q[1] <= 1'b0;
                    clr_q     <= S_AXI_WSTRB[0] & S_AXI_WDATA[1];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read FSM
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d     = r_state_q;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                S_AXI_ARREADY = 1'b1;
                r_state_d     = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rd_mux  = '0;
        rd_resp = 2'b00;
        case (S_AXI_ARADDR[4:2])
            3'd0: rd_mux = ctrl_q;
            3'd1: rd_mux = timeout_q;
            3'd2: rd_mux = scratch0_q;
            3'd3: rd_mux = scratch1_q;
            3'd4: rd_mux = {26'd0, invalid_q, hall_stall, dir_q, sync2_q};
            3'd5: rd_mux = pos_q;
            3'd6: rd_mux = period_q;
            default: begin
                rd_mux = '0;
`ifdef HALL_SLVERR_EN
                rd_resp = 2'b10;
`endif
            end
        endcase
    end

    // Capture on the ARREADY edge; a write committing on the same edge is not
    // yet visible, so the read returns the pre-write value.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else if (r_state_q == R_ADDR) begin
            rdata_q <= rd_mux;
            rresp_q <= rd_resp;
        end
    end

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

    // -------------------------------------------------------------- Hall decode
    function automatic logic [2:0] hall_next(input logic [2:0] s);
        case (s)
            3'b001:  hall_next = 3'b011;
            3'b011:  hall_next = 3'b010;
            3'b010:  hall_next = 3'b110;
            3'b110:  hall_next = 3'b100;
            3'b100:  hall_next = 3'b101;
            3'b101:  hall_next = 3'b001;
            default: hall_next = s;  // illegal code: no change can match it
        endcase
    endfunction

    function automatic logic [2:0] hall_prev(input logic [2:0] s);
        case (s)
            3'b011:  hall_prev = 3'b001;
            3'b010:  hall_prev = 3'b011;
            3'b110:  hall_prev = 3'b010;
            3'b100:  hall_prev = 3'b110;
            3'b101:  hall_prev = 3'b100;
            3'b001:  hall_prev = 3'b101;
            default: hall_prev = s;
        endcase
    endfunction

    assign hall_change = (sync2_q != prev_q);
    assign step_fwd    = hall_change && (sync2_q == hall_next(prev_q));
    assign step_bwd    = hall_change && (sync2_q == hall_prev(prev_q));
    assign step_bad    = hall_change && !step_fwd && !step_bwd;
    assign step_up     = step_fwd ^ dir_invert;

    always_comb begin
        pos_d     = pos_q;
        period_d  = period_q;
        cnt_d     = cnt_q;
        invalid_d = invalid_q;
        dir_d     = dir_q;
        if (enable) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 32'd1;
            end
            if (step_fwd || step_bwd) begin
                period_d = (cnt_q == '1) ? '1 : cnt_q + 32'd1;
                cnt_d    = '0;
                pos_d    = step_up ? pos_q + 32'd1 : pos_q - 32'd1;
                dir_d    = step_up;
            end
            if (step_bad) begin
                invalid_d = 1'b1;
            end
        end
        // Clear overrides everything, including an edge arriving this cycle.
        if (clr_q) begin
            pos_d     = '0;
            period_d  = '0;
            cnt_d     = '0;
            invalid_d = 1'b0;
            dir_d     = dir_q;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pos_q     <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            invalid_q <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            sync1_q   <= hall_in;
            sync2_q   <= sync1_q;
            // tracks even while disabled so re-enabling never sees a stale edge
            prev_q    <= sync2_q;
            pos_q     <= pos_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            invalid_q <= invalid_d;
            dir_q     <= dir_d;
        end
    end

    assign hall_dir   = dir_q;
    assign hall_stall = (timeout_q != '0) && enable && (cnt_q >= timeout_q);

endmodule
